// File: rtl/rs_age_ordered.sv
// Age-ordered reservation station: CDB wakeup, per-class oldest-ready-first issue, flush and credit.
// Optional macro RS_WAKEUP_BYPASS_EN lets same-cycle CDB hits make resident entries selectable.
package rs_age_ordered_pkg;
   localparam int XLEN  = 32;
   localparam int PRN_W = 6;
   localparam int FU_W  = 2;
   localparam int ROB_W = 8;

   typedef struct packed {
      logic             valid;
      logic [FU_W-1:0]  fu;
      logic [PRN_W-1:0] dest_prn;
      logic [ROB_W-1:0] rob_idx;
      logic             op1_ready;
      logic [PRN_W-1:0] op1_tag;
      logic [XLEN-1:0]  op1_val;
      logic             op2_ready;
      logic [PRN_W-1:0] op2_tag;
      logic [XLEN-1:0]  op2_val;
   } RS_ENTRY;

   typedef struct packed {
      logic [PRN_W-1:0] dest_prn;
      logic [XLEN-1:0]  value;
   } CDB_PACKET;

   typedef struct packed {
      logic [FU_W-1:0]  fu;
      logic [PRN_W-1:0] dest_prn;
      logic [ROB_W-1:0] rob_idx;
      logic [XLEN-1:0]  op1;
      logic [XLEN-1:0]  op2;
   } FU_PACKET;
endpackage

module rs_age_ordered
   import rs_age_ordered_pkg::*;
#(
   parameter int SIZE            = 16,
   parameter int DISPATCH_W      = 2,
   parameter int CDB_W           = 2,
   parameter int NUM_CLASS       = 4,
   parameter int PORTS_PER_CLASS = 2,
   parameter int ALERT_DEPTH     = 2,
   localparam int P     = NUM_CLASS * PORTS_PER_CLASS,
   localparam int CNT_W = $clog2(SIZE + 1),
   localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  RS_ENTRY   [DISPATCH_W-1:0] dispatch_entries,
   output logic                       dispatch_accept,
   input  CDB_PACKET [CDB_W-1:0]      cdb_packet,
   input  logic                       flush,
   output logic      [P-1:0]          issue_valid,
   output FU_PACKET  [P-1:0]          issue_packet,
   input  logic      [P-1:0]          issue_ready,
   output logic      [CNT_W-1:0]      free_slots,
   output logic                       almost_full
);

   RS_ENTRY  [SIZE-1:0]           entry_q, entry_d, ent_wk_s;
   logic     [SIZE-1:0][SIZE-1:0] age_q, age_d;
   logic     [CNT_W-1:0]          free_q, free_d;
   logic     [P-1:0]              issue_valid_q, issue_valid_d;
   FU_PACKET [P-1:0]              issue_packet_q, issue_packet_d;

   logic [SIZE-1:0]  cand_s, grant_s, elig_s, pick_s, taken_s, stay_s;
   logic [P-1:0]     port_load_s;
   logic [IDX_W-1:0] port_idx_s [P];
   logic [IDX_W-1:0] lane_slot_s [DISPATCH_W];
   logic [DISPATCH_W-1:0] lane_on_s;
   logic [CNT_W-1:0] iss_cnt_s, lane_cnt_s, acc_cnt_s;
   logic             port_free_s, rdy_s, found_s;

   function automatic RS_ENTRY wake(input RS_ENTRY e, input CDB_PACKET [CDB_W-1:0] cdb);
      RS_ENTRY r;
      r = e;
      for (int c = 0; c < CDB_W; c++) begin
         if (cdb[c].dest_prn != '0 && !r.op1_ready && r.op1_tag == cdb[c].dest_prn) begin
            r.op1_ready = 1'b1;
            r.op1_val   = cdb[c].value;
         end
         if (cdb[c].dest_prn != '0 && !r.op2_ready && r.op2_tag == cdb[c].dest_prn) begin
            r.op2_ready = 1'b1;
            r.op2_val   = cdb[c].value;
         end
      end
      return r;
   endfunction

   function automatic FU_PACKET to_pkt(input RS_ENTRY e);
      FU_PACKET f;
      f.fu       = e.fu;
      f.dest_prn = e.dest_prn;
      f.rob_idx  = e.rob_idx;
      f.op1      = e.op1_val;
      f.op2      = e.op2_val;
      return f;
   endfunction

   // Wakeup and per-port oldest-first select; ports of a class are contiguous, so ascending p keeps port order.
   always_comb begin
      ent_wk_s    = entry_q;
      cand_s      = '0;
      grant_s     = '0;
      elig_s      = '0;
      pick_s      = '0;
      port_load_s = '0;
      port_free_s = 1'b0;
      rdy_s       = 1'b0;
      iss_cnt_s   = '0;
      for (int p = 0; p < P; p++) port_idx_s[p] = '0;
      for (int i = 0; i < SIZE; i++) begin
         ent_wk_s[i] = wake(entry_q[i], cdb_packet);
`ifdef RS_WAKEUP_BYPASS_EN
         rdy_s = ent_wk_s[i].op1_ready && ent_wk_s[i].op2_ready;
`else
         rdy_s = entry_q[i].op1_ready && entry_q[i].op2_ready;
`endif
         cand_s[i] = entry_q[i].valid && rdy_s;
      end
      for (int p = 0; p < P; p++) begin
         port_free_s = !issue_valid_q[p] || issue_ready[p];
         for (int i = 0; i < SIZE; i++)
            elig_s[i] = cand_s[i] && !grant_s[i] && (entry_q[i].fu == FU_W'(p / PORTS_PER_CLASS));
         for (int i = 0; i < SIZE; i++) begin
            pick_s[i] = elig_s[i];
            for (int j = 0; j < SIZE; j++) pick_s[i] = pick_s[i] && !(elig_s[j] && age_q[j][i]);
         end
         port_load_s[p] = port_free_s && (|pick_s);
         for (int i = 0; i < SIZE; i++) begin
            if (port_load_s[p] && pick_s[i]) begin
               grant_s[i]    = 1'b1;
               port_idx_s[p] = IDX_W'(i);
            end else begin
               grant_s[i] = grant_s[i];
            end
         end
      end
      for (int i = 0; i < SIZE; i++) iss_cnt_s = iss_cnt_s + CNT_W'(grant_s[i]);
   end

   // All-or-nothing dispatch into the lowest free slots as seen at the start of the cycle.
   always_comb begin
      lane_cnt_s = '0;
      taken_s    = '0;
      found_s    = 1'b0;
      lane_on_s  = '0;
      for (int l = 0; l < DISPATCH_W; l++) lane_cnt_s = lane_cnt_s + CNT_W'(dispatch_entries[l].valid);
      dispatch_accept = (lane_cnt_s <= free_q) && !flush;
      for (int l = 0; l < DISPATCH_W; l++) begin
         lane_on_s[l]   = dispatch_entries[l].valid && dispatch_accept;
         lane_slot_s[l] = '0;
         found_s        = 1'b0;
         for (int i = 0; i < SIZE; i++) begin
            if (lane_on_s[l] && !found_s && !entry_q[i].valid && !taken_s[i]) begin
               taken_s[i]     = 1'b1;
               lane_slot_s[l] = IDX_W'(i);
               found_s        = 1'b1;
            end else begin
               found_s = found_s;
            end
         end
      end
   end

   // Next state for entries, age matrix, credit and issue registers; flush overrides everything.
   always_comb begin
      entry_d        = ent_wk_s;
      age_d          = '0;
      stay_s         = '0;
      issue_valid_d  = issue_valid_q;
      issue_packet_d = issue_packet_q;
      acc_cnt_s      = dispatch_accept ? lane_cnt_s : '0;
      free_d         = free_q - acc_cnt_s + iss_cnt_s;
      for (int i = 0; i < SIZE; i++) begin
         stay_s[i]         = entry_q[i].valid && !grant_s[i];
         entry_d[i].valid  = stay_s[i];
      end
      for (int i = 0; i < SIZE; i++)
         for (int j = 0; j < SIZE; j++) age_d[i][j] = age_q[i][j] && stay_s[i] && stay_s[j];
      for (int l = 0; l < DISPATCH_W; l++) begin
         if (lane_on_s[l]) begin
            entry_d[lane_slot_s[l]] = wake(dispatch_entries[l], cdb_packet);
            for (int j = 0; j < SIZE; j++) age_d[j][lane_slot_s[l]] = stay_s[j];
            for (int m = 0; m < DISPATCH_W; m++)
               age_d[lane_slot_s[m]][lane_slot_s[l]] = age_d[lane_slot_s[m]][lane_slot_s[l]] |
                                                        ((m < l) && lane_on_s[m]);
         end else begin
            entry_d = entry_d;
         end
      end
      for (int p = 0; p < P; p++) begin
         if (port_load_s[p]) begin
            issue_valid_d[p]  = 1'b1;
            issue_packet_d[p] = to_pkt(ent_wk_s[port_idx_s[p]]);
         end else if (issue_valid_q[p] && !issue_ready[p]) begin
            issue_valid_d[p] = 1'b1;
         end else begin
            issue_valid_d[p] = 1'b0;
         end
      end
      if (flush) begin
         for (int i = 0; i < SIZE; i++) entry_d[i].valid = 1'b0;
         age_d          = '0;
         issue_valid_d  = '0;
         issue_packet_d = '0;
         free_d         = CNT_W'(SIZE);
      end else begin
         free_d = free_d;
      end
   end

   // State registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         entry_q        <= '0;
         age_q          <= '0;
         free_q         <= CNT_W'(SIZE);
         issue_valid_q  <= '0;
         issue_packet_q <= '0;
      end else begin
         entry_q        <= entry_d;
         age_q          <= age_d;
         free_q         <= free_d;
         issue_valid_q  <= issue_valid_d;
         issue_packet_q <= issue_packet_d;
      end
   end

   assign issue_valid  = issue_valid_q;
   assign issue_packet = issue_packet_q;
   assign free_slots   = free_q;
   assign almost_full  = (free_q < CNT_W'(ALERT_DEPTH));

endmodule

// File: tb/tb_rs_age_ordered.sv
// Directed bench for rs_age_ordered; expectations adapt to RS_WAKEUP_BYPASS_EN.
module tb_rs_age_ordered;
   import rs_age_ordered_pkg::*;

`ifdef RS_WAKEUP_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic                 clock;
   logic                 reset;
   RS_ENTRY   [1:0]      dispatch_entries;
   logic                 dispatch_accept;
   CDB_PACKET [1:0]      cdb_packet;
   logic                 flush;
   logic      [7:0]      issue_valid;
   FU_PACKET  [7:0]      issue_packet;
   logic      [7:0]      issue_ready;
   logic      [4:0]      free_slots;
   logic                 almost_full;

   int err_cnt = 0;
   int chk_cnt = 0;

   FU_PACKET [7:0] rec_a, rec_b, rec_c;
   logic     [7:0] vld_a, vld_b, vld_c;

   rs_age_ordered dut (
      .clock            (clock),
      .reset            (reset),
      .dispatch_entries (dispatch_entries),
      .dispatch_accept  (dispatch_accept),
      .cdb_packet       (cdb_packet),
      .flush            (flush),
      .issue_valid      (issue_valid),
      .issue_packet     (issue_packet),
      .issue_ready      (issue_ready),
      .free_slots       (free_slots),
      .almost_full      (almost_full)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic RS_ENTRY mk(input logic [1:0] fu, input logic [7:0] rob, input logic r1,
                                  input logic [5:0] t1, input logic [31:0] v1);
      RS_ENTRY e;
      e           = '0;
      e.valid     = 1'b1;
      e.fu        = fu;
      e.rob_idx   = rob;
      e.dest_prn  = 6'd30;
      e.op1_ready = r1;
      e.op1_tag   = t1;
      e.op1_val   = v1;
      e.op2_ready = 1'b1;
      e.op2_val   = 32'd5;
      return e;
   endfunction

   initial begin
      reset = 1'b1;
      flush = 1'b0;
      dispatch_entries = '0;
      cdb_packet = '0;
      issue_ready = 8'hFF;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      #1;
      check("rst_free", free_slots, 64'd16);
      check("rst_af", almost_full, 64'd0);
      check("rst_iv", issue_valid, 64'd0);
      check("rst_acc", dispatch_accept, 64'd1);

      // Three ready ALU entries over two cycles.
      dispatch_entries[0] = mk(2'd0, 8'd1, 1'b1, 6'd0, 32'd11);
      dispatch_entries[1] = mk(2'd0, 8'd2, 1'b1, 6'd0, 32'd12);
      #1 check("alu_acc", dispatch_accept, 64'd1);
      tick();
      dispatch_entries = '0;
      dispatch_entries[0] = mk(2'd0, 8'd3, 1'b1, 6'd0, 32'd13);
      tick();
      dispatch_entries = '0;
      check("alu_iv1", issue_valid, 64'h03);
      check("alu_p0_A", issue_packet[0].rob_idx, 64'd1);
      check("alu_p1_B", issue_packet[1].rob_idx, 64'd2);
      check("alu_free15", free_slots, 64'd15);
      tick();
      check("alu_iv2", issue_valid, 64'h01);
      check("alu_p0_C", issue_packet[0].rob_idx, 64'd3);
      check("alu_free16", free_slots, 64'd16);

      // MULT class lands on port 2.
      dispatch_entries[0] = mk(2'd1, 8'd50, 1'b1, 6'd0, 32'd7);
      tick();
      dispatch_entries = '0;
      tick();
      check("mul_iv", issue_valid, 64'h04);
      check("mul_rob", issue_packet[2].rob_idx, 64'd50);

      // Wakeup from CDB on prn 7.
      dispatch_entries[0] = mk(2'd0, 8'd4, 1'b0, 6'd7, 32'd0);
      tick();
      dispatch_entries = '0;
      cdb_packet[0].dest_prn = 6'd7;
      cdb_packet[0].value    = 32'h1234;
      #1 check("wk_pre", issue_valid[0], 64'd0);
      tick();
      cdb_packet = '0;
      vld_a = issue_valid; rec_a = issue_packet;
      tick();
      vld_b = issue_valid; rec_b = issue_packet;
      check("wk_iv_t1", vld_a[0], 64'(BYP));
      check("wk_iv_t2", vld_b[0], 64'(!BYP));
      check("wk_op1", BYP ? rec_a[0].op1 : rec_b[0].op1, 64'h1234);
      check("wk_op2", BYP ? rec_a[0].op2 : rec_b[0].op2, 64'd5);
      tick();
      check("wk_drain", issue_valid, 64'd0);

      // Stall on port 0 holds X while Y goes to port 1.
      dispatch_entries[0] = mk(2'd0, 8'd10, 1'b1, 6'd0, 32'hAAAA);
      tick();
      dispatch_entries = '0;
      issue_ready[0] = 1'b0;
      tick();
      check("hold_x_in", issue_packet[0].rob_idx, 64'd10);
      dispatch_entries[0] = mk(2'd0, 8'd11, 1'b1, 6'd0, 32'hBBBB);
      tick();
      dispatch_entries = '0;
      check("hold_1", {issue_valid, issue_packet[0].rob_idx}, {8'h01, 8'd10});
      tick();
      check("hold_2", {issue_valid, issue_packet[0].rob_idx, issue_packet[1].rob_idx}, {8'h03, 8'd10, 8'd11});
      check("hold_x_op1", issue_packet[0].op1, 64'hAAAA);
      tick();
      check("hold_3", {issue_valid, issue_packet[0].rob_idx}, {8'h01, 8'd10});
      issue_ready[0] = 1'b1;
      tick();
      check("hold_rel", issue_valid, 64'd0);

      // Age order beats slot order: W3 sits in slot 0 but is youngest.
      dispatch_entries[0] = mk(2'd0, 8'd40, 1'b1, 6'd0, 32'd1);
      dispatch_entries[1] = mk(2'd0, 8'd41, 1'b0, 6'd9, 32'd0);
      tick();
      dispatch_entries = '0;
      dispatch_entries[0] = mk(2'd0, 8'd42, 1'b0, 6'd9, 32'd0);
      tick();
      dispatch_entries[0] = mk(2'd0, 8'd43, 1'b0, 6'd9, 32'd0);
      tick();
      dispatch_entries = '0;
      cdb_packet[1].dest_prn = 6'd9;
      cdb_packet[1].value    = 32'h99;
      tick();
      cdb_packet = '0;
      vld_a = issue_valid; rec_a = issue_packet;
      tick();
      vld_b = issue_valid; rec_b = issue_packet;
      tick();
      vld_c = issue_valid; rec_c = issue_packet;
      check("age_iv1", BYP ? vld_a : vld_b, 64'h03);
      check("age_p0", BYP ? rec_a[0].rob_idx : rec_b[0].rob_idx, 64'd41);
      check("age_p1", BYP ? rec_a[1].rob_idx : rec_b[1].rob_idx, 64'd42);
      check("age_iv2", BYP ? vld_b : vld_c, 64'h01);
      check("age_p0_last", BYP ? rec_b[0].rob_idx : rec_c[0].rob_idx, 64'd43);
      tick();
      tick();
      check("age_free", free_slots, 64'd16);

      // Fill to 15 with waiting entries, then probe the credit boundary.
      for (int n = 0; n < 7; n++) begin
         dispatch_entries[0] = mk(2'd0, 8'(60 + 2 * n), 1'b0, 6'd20, 32'd0);
         dispatch_entries[1] = mk(2'd0, 8'(61 + 2 * n), 1'b0, 6'd20, 32'd0);
         tick();
      end
      dispatch_entries[1] = '0;
      tick();
      check("fill_15", free_slots, 64'd1);
      dispatch_entries[0] = mk(2'd0, 8'd80, 1'b0, 6'd20, 32'd0);
      dispatch_entries[1] = mk(2'd0, 8'd81, 1'b0, 6'd20, 32'd0);
      #1;
      check("full_rej_acc", dispatch_accept, 64'd0);
      check("full_af1", almost_full, 64'd1);
      tick();
      check("full_rej_free", free_slots, 64'd1);
      dispatch_entries[1] = '0;
      #1 check("full_one_acc", dispatch_accept, 64'd1);
      tick();
      dispatch_entries = '0;
      check("full_free0", free_slots, 64'd0);
      check("full_af", almost_full, 64'd1);
      dispatch_entries[0] = mk(2'd0, 8'd82, 1'b1, 6'd0, 32'd0);
      #1 check("full_zero_acc", dispatch_accept, 64'd0);

      // Flush with dispatch and a CDB hit in the same cycle.
      flush = 1'b1;
      dispatch_entries[1] = mk(2'd0, 8'd83, 1'b1, 6'd0, 32'd0);
      cdb_packet[0].dest_prn = 6'd20;
      cdb_packet[0].value    = 32'hABCD;
      #1 check("fl_acc", dispatch_accept, 64'd0);
      tick();
      flush = 1'b0;
      dispatch_entries = '0;
      cdb_packet = '0;
      check("fl_free", free_slots, 64'd16);
      check("fl_iv", issue_valid, 64'd0);
      check("fl_af", almost_full, 64'd0);
      repeat (3) tick();
      check("fl_quiet_iv", issue_valid, 64'd0);
      check("fl_quiet_free", free_slots, 64'd16);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/rs_age_ordered.md
Name: rs_age_ordered

Overview:
- Parametrised reservation station, successor to the current single-mode RS.
- Holds up to SIZE renamed instructions and snoops C CDB channels for operand wakeup.
- Issues ready entries to NUM_CLASS functional-unit classes, each with K_c ports, always oldest-ready-first via an age matrix.
- Adds a per-port valid/ready handshake, a full flush, and stall-aware credit (free_slots); sits between dispatch and the FU bank.

Parameters:
- SIZE, 16, number of entries.
- DISPATCH_W, `N, max entries accepted per cycle.
- CDB_W, `N, CDB channels snooped per cycle.
- NUM_CLASS, 4, FU classes (ALU, MULT, LOAD, STORE); the class of an entry is RS_ENTRY.fu.
- PORTS_PER_CLASS, 2, issue ports per class; total ports P = NUM_CLASS*PORTS_PER_CLASS.
- ALERT_DEPTH, `N, almost_full threshold margin.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- dispatch_entries  in  DISPATCH_W x RS_ENTRY  new entries; a lane is valid when its .valid is set.
- dispatch_accept  out  1  all valid lanes are accepted this cycle.
- cdb_packet  in  CDB_W x CDB_PACKET  broadcast results; dest_prn==0 means an idle channel.
- flush  in  1  mispredict/exception: drop all entries.
- issue_valid  out  P  port p holds a valid packet.
- issue_packet  out  P x FU_PACKET  registered issue packet.
- issue_ready  in  P  FU port p accepts this cycle.
- free_slots  out  $clog2(SIZE+1)  count of invalid entries (registered).
- almost_full  out  1  free_slots < ALERT_DEPTH.

Behaviour:
- Reset (async): all entries invalid, age matrix cleared, issue_valid=0, issue_packet=0, free_slots=SIZE, almost_full=0, dispatch_accept=1.
- Dispatch is all-or-nothing.
  - dispatch_accept = (count of valid lanes <= free_slots) && !flush.
  - Accepted lanes fill the lowest-index free entries in lane order; lane 0 is older than lane 1.
  - A new entry's age row is set to "younger than every currently valid entry and every lower lane".
- Wakeup:
  - For every valid entry and every dispatched lane, for each CDB channel with dest_prn!=0: if op1 (op2) is not ready and its tag equals dest_prn, set it ready and capture the value.
  - Same-cycle CDB hits on dispatched lanes are captured, so no wakeup is lost.
- Select, per class:
  - Candidates are valid entries with both operands ready and a matching fu.
  - A port is free when !issue_valid[p] || issue_ready[p].
  - Free ports of a class receive, in ascending port order, the oldest remaining candidates.
- Issue latency is 1 cycle.
  - A granted entry is invalidated at the clock edge, and issue_packet/issue_valid load it at that same edge.
  - A port with issue_valid && !issue_ready holds its packet unchanged.
  - A port with nothing to load drops issue_valid to 0.
- An entry becomes ready from a CDB hit in cycle t. It is a select candidate no earlier than cycle t+1, unless RS_WAKEUP_BYPASS_EN is defined.
- Age matrix: bit [i][j]=1 means i is older than j. Freeing entry i clears row i and column i. The matrix stays a strict total order over valid entries.
- free_slots update: next = free_slots − accepted + issued. SIZE accepts with zero issues yields 0; it never underflows or overflows.
- Flush takes priority over everything in the same cycle.
  - All entries become invalid and issue_valid goes to 0 on the next edge.
  - No dispatch is accepted; free_slots becomes SIZE.
  - Any handshakes in flight are discarded.
- Simultaneous dispatch into a slot freed this cycle is forbidden: the fill uses free_slots/valid bits from the start of the cycle.

Optional Feature:
- RS_WAKEUP_BYPASS_EN.
- Defined: select also treats as ready any operand matched by a CDB hit in the current cycle, for already-valid entries only. Such an entry can issue in cycle t with the CDB value forwarded into issue_packet. This gives back-to-back dependent issue.
- Undefined: select uses registered ready bits only, giving a one-cycle wakeup-to-issue bubble.

Test Plan:
- Reset with flush=0, no dispatch -> free_slots=16, almost_full=0, issue_valid=0 on all ports, dispatch_accept=1.
- Dispatch 3 ALU entries over 2 cycles (A,B then C), all operands ready, issue_ready=1 -> cycle after: ports 0,1 carry A,B in that order; next cycle port 0 carries C; free_slots returns to 16.
- An ALU entry waiting on prn 7, CDB dest_prn=7 value 0x1234 at cycle t -> issue_packet.op1=0x1234. Bypass off: issue_valid at t+2. RS_WAKEUP_BYPASS_EN: at t+1.
- ALU port 0 with issue_ready=0 for 3 cycles holding X -> X is held stable. A ready entry Y goes to port 1; Y is not issued on port 0 until ready rises.
- Fill 15 entries and present 2 lanes -> dispatch_accept=0 and free_slots stays 1. Present 1 lane -> accepted, free_slots=0, almost_full=1.
- Assert flush in the same cycle as 2 valid lanes and a CDB hit -> next cycle free_slots=16, all issue_valid=0, nothing issues afterwards.
